// File: rtl/ibex_l2_rf_arbiter.sv
// Round-robin arbiter for the single-port L2 register file: one access per cycle,
// x0 writes suppressed, registered read data. Burst locking is built with IBEX_L2_RF_LOCK_EN.
module ibex_l2_rf_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned DataWidth = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumReq-1:0]               req_i,
  input  logic [NumReq-1:0]               we_i,
  input  logic [NumReq-1:0][4:0]          addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0] wdata_i,
`ifdef IBEX_L2_RF_LOCK_EN
  input  logic [NumReq-1:0]               lock_i,
`endif
  output logic [NumReq-1:0]               gnt_o,
  output logic [NumReq-1:0]               rvalid_o,
  output logic [DataWidth-1:0]            rdata_o,
  output logic [4:0]                      rf_addr_o,
  output logic [DataWidth-1:0]            rf_wdata_o,
  output logic                            rf_we_o,
  input  logic [DataWidth-1:0]            rf_rdata_i
);

  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  logic [PtrW-1:0]      ptr_q;
  logic [NumReq-1:0]    rvalid_q;
  logic [DataWidth-1:0] rdata_q;

  logic [NumReq-1:0]    elig;
  logic [NumReq-1:0]    gnt;
  logic                 gnt_valid;
  logic [PtrW-1:0]      gnt_idx;
  logic [PtrW-1:0]      ptr_next;
  logic                 sel_we;
  logic [4:0]           sel_addr;
  logic                 ptr_adv;

`ifdef IBEX_L2_RF_LOCK_EN
  logic                 locked_q;
  logic [PtrW-1:0]      owner_q;

  // While a burst is locked only the owner is eligible.
  always_comb begin
    elig = req_i;
    if (locked_q) begin
      elig          = '0;
      elig[owner_q] = req_i[owner_q];
    end
  end

  assign ptr_adv = gnt_valid && !locked_q;
`else
  assign elig    = req_i;
  assign ptr_adv = gnt_valid;
`endif

  // Search eligible requesters starting at the priority pointer, wrapping modulo NumReq.
  always_comb begin
    int unsigned cand;
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cand      = 0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!gnt_valid && elig[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[PtrW-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

  assign sel_we   = we_i[gnt_idx];
  assign sel_addr = addr_i[gnt_idx];
  assign ptr_next = (gnt_idx == PtrW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;

  // Outputs are forced quiet while reset is asserted, so the file sees no access.
  assign gnt_o      = rst_ni ? gnt : '0;
  assign rf_addr_o  = (rst_ni && gnt_valid) ? sel_addr : '0;
  assign rf_wdata_o = (rst_ni && gnt_valid) ? wdata_i[gnt_idx] : '0;
  assign rf_we_o    = rst_ni && gnt_valid && sel_we && (sel_addr != '0);
  assign rvalid_o   = rvalid_q;
  assign rdata_o    = rdata_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt;
      if (gnt_valid) begin
        rdata_q <= (sel_we || (sel_addr == '0)) ? '0 : rf_rdata_i;
      end
      if (ptr_adv) ptr_q <= ptr_next;
    end
  end

`ifdef IBEX_L2_RF_LOCK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      locked_q <= 1'b0;
      owner_q  <= '0;
    end else if (locked_q) begin
      if (!req_i[owner_q] || (gnt_valid && !lock_i[owner_q])) locked_q <= 1'b0;
    end else if (gnt_valid && lock_i[gnt_idx]) begin
      locked_q <= 1'b1;
      owner_q  <= gnt_idx;
    end
  end
`endif

endmodule

// File: tb/tb_ibex_l2_rf_arbiter.sv
// Directed testbench for ibex_l2_rf_arbiter with a small behavioural register file model.
// Lock scenario is exercised only when IBEX_L2_RF_LOCK_EN is defined.
module tb_ibex_l2_rf_arbiter;

  logic             clk;
  logic             rst_ni;
  logic [1:0]       req, we, lock;
  logic [1:0][4:0]  addr;
  logic [1:0][31:0] wdata;
  logic [1:0]       gnt, rvalid;
  logic [31:0]      rdata, rf_wdata, rf_rdata;
  logic [4:0]       rf_addr;
  logic             rf_we;

  int n_cmp = 0;
  int n_err = 0;

  ibex_l2_rf_arbiter #(.NumReq(2), .DataWidth(32)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .req_i      (req),
    .we_i       (we),
    .addr_i     (addr),
    .wdata_i    (wdata),
`ifdef IBEX_L2_RF_LOCK_EN
    .lock_i     (lock),
`endif
    .gnt_o      (gnt),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .rf_addr_o  (rf_addr),
    .rf_wdata_o (rf_wdata),
    .rf_we_o    (rf_we),
    .rf_rdata_i (rf_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: unwritten entries read 0xA000_00nn (x0 reads non-zero here on purpose).
  logic        rf_clr_n;
  logic [31:0] rf_written;
  logic [31:0] rf_mem [32];

  always @(posedge clk or negedge rf_clr_n) begin
    if (!rf_clr_n) rf_written <= '0;
    else if (rf_we) begin
      rf_written[rf_addr] <= 1'b1;
      rf_mem[rf_addr]     <= rf_wdata;
    end
  end

  assign rf_rdata = rf_written[rf_addr] ? rf_mem[rf_addr] : (32'hA000_0000 + {27'b0, rf_addr});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    req = '0; we = '0; lock = '0;
  endtask

  task automatic drv(input int r, input logic w, input logic [4:0] a, input logic [31:0] d);
    req[r] = 1'b1; we[r] = w; addr[r] = a; wdata[r] = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int rv0, rv1;
    rv0 = 0; rv1 = 0;
    rf_clr_n = 1'b0;
    rst_ni   = 1'b0;
    addr = '0; wdata = '0;
    idle();
    drv(0, 1'b1, 5'd3, 32'h1111_1111);
    drv(1, 1'b1, 5'd4, 32'h2222_2222);
    #1 rf_clr_n = 1'b1;

    // Reset: all outputs quiet even with requests pending
    @(negedge clk);
    check("rst_gnt",    gnt,    '0);
    check("rst_rvalid", rvalid, '0);
    check("rst_rdata",  rdata,  '0);
    check("rst_we",     rf_we,  '0);
    check("rst_addr",   rf_addr, '0);
    tick();
    rst_ni = 1'b1;

    // First grant after reset goes to requester 0, then 1
    idle(); drv(0, 1'b0, 5'd1, 0); drv(1, 1'b0, 5'd2, 0);
    @(negedge clk);
    check("post_rst_gnt", gnt, 2'b01);
    check("post_rst_addr", rf_addr, 5'd1);
    tick();
    @(negedge clk);
    check("rr_gnt1",   gnt,     2'b10);
    check("rr_addr1",  rf_addr, 5'd2);
    check("rr_rv0",    rvalid,  2'b01);
    check("rr_rd0",    rdata,   32'hA000_0001);
    tick();
    idle();
    @(negedge clk);
    check("idle_gnt",  gnt,     2'b00);
    check("idle_addr", rf_addr, 5'd0);
    check("idle_we",   rf_we,   1'b0);
    check("rr_rv1",    rvalid,  2'b10);
    check("rr_rd1",    rdata,   32'hA000_0002);
    tick();

    // Write x5 then read x5 back-to-back
    idle(); drv(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    check("wr_gnt",   gnt,      2'b01);
    check("wr_we",    rf_we,    1'b1);
    check("wr_addr",  rf_addr,  5'd5);
    check("wr_wdata", rf_wdata, 32'hDEAD_BEEF);
    tick();
    idle(); drv(0, 1'b0, 5'd5, 0);
    @(negedge clk);
    check("rd_gnt",    gnt,    2'b01);
    check("rd_we",     rf_we,  1'b0);
    check("wr_rvalid", rvalid, 2'b01);
    check("wr_rdata",  rdata,  32'h0);
    tick();
    idle();
    @(negedge clk);
    check("rd_rvalid", rvalid, 2'b01);
    check("rd_rdata",  rdata,  32'hDEAD_BEEF);
    tick();

    // x0: write acknowledged but suppressed, read returns 0
    idle(); drv(1, 1'b1, 5'd0, 32'h1234_5678);
    @(negedge clk);
    check("x0w_gnt", gnt,   2'b10);
    check("x0w_we",  rf_we, 1'b0);
    tick();
    idle(); drv(1, 1'b0, 5'd0, 0);
    @(negedge clk);
    check("x0r_gnt",   gnt,    2'b10);
    check("x0w_rvalid", rvalid, 2'b10);
    tick();
    idle();
    @(negedge clk);
    check("x0r_rvalid", rvalid, 2'b10);
    check("x0r_rdata",  rdata,  32'h0);
    tick();

    // Idle skip: only requester 1, pointer at 0
    idle(); drv(1, 1'b0, 5'd2, 0);
    @(negedge clk);
    check("skip_gnt", gnt, 2'b10);
    tick();

    // Fairness: both hold requests for 6 cycles
    idle(); drv(0, 1'b0, 5'd3, 0); drv(1, 1'b0, 5'd4, 0);
    for (int c = 0; c < 7; c++) begin
      if (c == 6) idle();
      @(negedge clk);
      check("fair_gnt", gnt, (c == 6) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10));
      if (c == 0) begin
        check("skip_rvalid", rvalid, 2'b10);
        check("skip_rdata",  rdata,  32'hA000_0002);
      end else begin
        rv0 += int'(rvalid[0]);
        rv1 += int'(rvalid[1]);
        check("fair_rdata", rdata, ((c - 1) % 2 == 0) ? 32'hA000_0003 : 32'hA000_0004);
      end
      tick();
    end
    check("fair_rv0_cnt", 32'(rv0), 32'd3);
    check("fair_rv1_cnt", 32'(rv1), 32'd3);

    // Same-address write (req0) and read (req1) together: pointer order decides
    idle(); drv(0, 1'b1, 5'd7, 32'h0BAD_F00D); drv(1, 1'b0, 5'd7, 0);
    @(negedge clk);
    check("race_gnt0", gnt,   2'b01);
    check("race_we",   rf_we, 1'b1);
    tick();
    req[0] = 1'b0;
    @(negedge clk);
    check("race_gnt1", gnt, 2'b10);
    tick();
    idle();
    @(negedge clk);
    check("race_rvalid", rvalid, 2'b10);
    check("race_rdata",  rdata,  32'h0BAD_F00D);
    tick();

    // Reset mid-operation with a pending rvalid and pointer at 1
    idle(); drv(0, 1'b0, 5'd1, 0);
    @(negedge clk);
    check("mid_gnt", gnt, 2'b01);
    tick();
    drv(1, 1'b0, 5'd2, 0);
    rst_ni = 1'b0;
    @(negedge clk);
    check("mid_rst_gnt",    gnt,    2'b00);
    check("mid_rst_rvalid", rvalid, 2'b00);
    check("mid_rst_rdata",  rdata,  32'h0);
    check("mid_rst_we",     rf_we,  1'b0);
    tick();
    rst_ni = 1'b1;
    @(negedge clk);
    check("mid_rel_gnt", gnt, 2'b01);
    tick();
    @(negedge clk);
    check("mid_rel_gnt2", gnt, 2'b10);
    tick();

`ifdef IBEX_L2_RF_LOCK_EN
    // Lock: req0 locks for two accesses then releases on the third; req1 waits
    idle(); drv(0, 1'b0, 5'd1, 0); drv(1, 1'b0, 5'd2, 0);
    for (int c = 0; c < 4; c++) begin
      lock[0] = (c < 2);
      @(negedge clk);
      check("lock_gnt", gnt, (c < 3) ? 2'b01 : 2'b10);
      tick();
    end
    idle();
    @(negedge clk);
    check("lock_rvalid", rvalid, 2'b10);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
